// File: rtl/irq_ctrl_if.sv
// Core-facing interrupt handshake plus the software register port of irq_ctrl.
// master = core/software side, slave = the controller.
interface irq_ctrl_if;
    logic        irq_en;
    logic        irq_ack;
    logic        irq_out;
    logic [3:0]  cause;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;

    modport master (
        output irq_en, irq_ack, reg_we, reg_addr, reg_wdata,
        input  irq_out, cause, reg_rdata
    );

    modport slave (
        input  irq_en, irq_ack, reg_we, reg_addr, reg_wdata,
        output irq_out, cause, reg_rdata
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises NSRC sources, latches edge requests, masks,
// picks the lowest-index active source and runs the request/ack handshake with the core.
module irq_ctrl #(
    parameter int unsigned NSRC        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_in,
    irq_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q;
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, edge_q;
    state_e          state_q;
    logic            irq_out_q;
    logic [3:0]      cause_q;
    logic            cause_valid_q;

    logic [NSRC-1:0] s_sync, rise, pending, active, sel_oh, clr;
    logic [3:0]      sel;
    logic            any, ack_take;
    logic            we_pend, we_mask, we_cause, we_edge;
    logic            unused_wdata;

    assign s_sync  = sync_q[SYNC_STAGES-1];
    assign rise    = s_sync & ~prev_q;
    // Level sources bypass the latch so they track the synchroniser output directly.
    assign pending = (pend_q & edge_q) | (s_sync & ~edge_q);
    assign active  = pending & mask_q;
    assign any     = |active;
    assign sel_oh  = active & ~(active - NSRC'(1));

    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) sel = 4'(i);
        end
    end

    assign ack_take = (state_q == StReq) && bus.irq_ack;
    assign we_pend  = bus.reg_we && (bus.reg_addr == 2'd0);
    assign we_mask  = bus.reg_we && (bus.reg_addr == 2'd1);
    assign we_cause = bus.reg_we && (bus.reg_addr == 2'd2);
    assign we_edge  = bus.reg_we && (bus.reg_addr == 2'd3);
    assign unused_wdata = ^bus.reg_wdata;

    always_comb begin
        clr = '0;
        if (we_pend)  clr = clr | bus.reg_wdata[NSRC-1:0];
        if (ack_take) clr = clr | sel_oh;
        // A fresh edge wins over a same-cycle clear.
        pend_d = (((pend_q & ~clr) | rise) & edge_q) | (s_sync & ~edge_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_in};
            prev_q <= s_sync;
            pend_q <= pend_d;
            if (we_mask) mask_q <= bus.reg_wdata[NSRC-1:0];
            if (we_edge) edge_q <= bus.reg_wdata[NSRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            irq_out_q     <= 1'b0;
            cause_q       <= '0;
            cause_valid_q <= 1'b0;
        end else begin
            if (we_cause) cause_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any && bus.irq_en) begin
                        state_q   <= StReq;
                        irq_out_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus.irq_ack) begin
                        cause_q       <= sel;
                        cause_valid_q <= 1'b1;
                        irq_out_q     <= 1'b0;
                        state_q       <= StWait;
                    end else if (!any || !bus.irq_en) begin
                        irq_out_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StWait: begin
                    // Hold off until the core has actually disabled interrupts.
                    irq_out_q <= 1'b0;
                    if (!bus.irq_en) state_q <= StIdle;
                end
                default: begin
                    irq_out_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        unique case (bus.reg_addr)
            2'd0: bus.reg_rdata[NSRC-1:0] = pending;
            2'd1: bus.reg_rdata[NSRC-1:0] = mask_q;
            2'd2: bus.reg_rdata = {cause_valid_q, 11'b0, cause_q};
            2'd3: bus.reg_rdata[NSRC-1:0] = edge_q;
            default: bus.reg_rdata = '0;
        endcase
    end

    assign bus.irq_out = irq_out_q;
    assign bus.cause   = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: edge/level requests, priority, withdraw, hold-off,
// set/clear collision, masking and asynchronous reset.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] src_in = '0;
    int         errors = 0;
    int         checks = 0;

    irq_ctrl_if bus ();

    irq_ctrl #(.NSRC(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .src_in (src_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [15:0] exp, input string tag);
        bus.reg_addr = a;
        #1;
        check(tag, bus.reg_rdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        tick();
        bus.reg_we    = 1'b0;
    endtask

    initial begin
        bus.irq_en    = 1'b0;
        bus.irq_ack   = 1'b0;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_irq_out", {15'b0, bus.irq_out}, 16'h0);
        chk_reg(2'd0, 16'h0000, "rst_pending");
        chk_reg(2'd1, 16'h0000, "rst_mask");
        chk_reg(2'd2, 16'h0000, "rst_cause");
        chk_reg(2'd3, 16'h00FF, "rst_edge_cfg");

        // Edge request on source 0
        wr(2'd1, 16'h0001);
        bus.irq_en = 1'b1;
        src_in = 8'h01;
        tick();
        src_in = 8'h00;
        tick();
        chk_reg(2'd0, 16'h0000, "edge_pend_early");
        tick();
        chk_reg(2'd0, 16'h0001, "edge_pend_3cyc");
        check("edge_irq_not_yet", {15'b0, bus.irq_out}, 16'h0);
        tick();
        check("edge_irq_out", {15'b0, bus.irq_out}, 16'h1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("edge_ack_irq_out", {15'b0, bus.irq_out}, 16'h0);
        check("edge_cause_port", {12'b0, bus.cause}, 16'h0);
        chk_reg(2'd2, 16'h8000, "edge_cause_reg");
        chk_reg(2'd0, 16'h0000, "edge_pend_cleared");
        bus.irq_en = 1'b0;
        tick();

        // Priority: sources 5 and 2 together
        wr(2'd1, 16'h00FF);
        src_in = 8'h24;
        tick();
        src_in = 8'h00;
        tick();
        tick();
        chk_reg(2'd0, 16'h0024, "prio_pending");
        bus.irq_en = 1'b1;
        tick();
        check("prio_irq_out", {15'b0, bus.irq_out}, 16'h1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("prio_cause_2", {12'b0, bus.cause}, 16'h2);
        chk_reg(2'd0, 16'h0020, "prio_pend_left");

        // WAIT hold-off while irq_en stays high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_holdoff", {15'b0, bus.irq_out}, 16'h0);
        end
        bus.irq_en = 1'b0;
        tick();
        bus.irq_en = 1'b1;
        tick();
        check("wait_rearm_irq", {15'b0, bus.irq_out}, 16'h1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("prio_cause_5", {12'b0, bus.cause}, 16'h5);
        chk_reg(2'd2, 16'h8005, "prio_cause_reg");
        chk_reg(2'd0, 16'h0000, "prio_pend_empty");
        bus.irq_en = 1'b0;
        tick();

        // Level withdraw on source 3
        wr(2'd2, 16'h0000);
        chk_reg(2'd2, 16'h0005, "cause_valid_cleared");
        wr(2'd3, 16'h0000);
        wr(2'd1, 16'h0008);
        bus.irq_en = 1'b1;
        src_in = 8'h08;
        tick();
        tick();
        chk_reg(2'd0, 16'h0008, "level_pend_2cyc");
        tick();
        check("level_irq_out", {15'b0, bus.irq_out}, 16'h1);
        src_in = 8'h00;
        tick();
        tick();
        check("level_still_req", {15'b0, bus.irq_out}, 16'h1);
        tick();
        check("level_withdrawn", {15'b0, bus.irq_out}, 16'h0);
        chk_reg(2'd2, 16'h0005, "level_cause_kept");
        bus.irq_en = 1'b0;

        // Set/clear collision on source 0
        wr(2'd3, 16'h00FF);
        wr(2'd1, 16'h0001);
        src_in = 8'h01;
        tick();
        tick();
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = 16'h0001;
        tick();
        bus.reg_we = 1'b0;
        src_in     = 8'h00;
        chk_reg(2'd0, 16'h0001, "collision_set_wins");
        wr(2'd0, 16'h0001);
        chk_reg(2'd0, 16'h0000, "w1c_clears");

        // Masked pending never requests
        wr(2'd1, 16'h0000);
        src_in = 8'h10;
        tick();
        src_in = 8'h00;
        tick();
        tick();
        chk_reg(2'd0, 16'h0010, "masked_pending");
        bus.irq_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("masked_no_irq", {15'b0, bus.irq_out}, 16'h0);
        end

        // Async reset mid-request
        wr(2'd1, 16'h0010);
        tick();
        check("pre_reset_irq", {15'b0, bus.irq_out}, 16'h1);
        #2;
        rst = 1'b1;
        #1;
        check("areset_irq_out", {15'b0, bus.irq_out}, 16'h0);
        chk_reg(2'd0, 16'h0000, "areset_pending");
        chk_reg(2'd1, 16'h0000, "areset_mask");
        chk_reg(2'd2, 16'h0000, "areset_cause");
        chk_reg(2'd3, 16'h00FF, "areset_edge_cfg");
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
